register_file_mp: RTL and testbench
===================================

# register_file_mp

Parametrised, clocked successor to the single-cycle CPU register file. It provides NUM_READ synchronous read ports and one write port, with optional write-to-read bypass and an optional hardwired-zero register 0. A built-in clear engine zeroes every entry after reset or on request. It sits between decode and execute and is sized for either the 64-bit/32-entry core or narrower test cores.

## Interface
Parameters:
- DATA_WIDTH, 64, width of each register
- ADDR_WIDTH, 5, address width; DEPTH = 2**ADDR_WIDTH entries
- NUM_READ, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = register 0 is read-only zero
- BYPASS, 1, 1 = same-cycle write is forwarded to a matching read

Ports:
- clk  input  1  clock; all state changes on rising edge
- reset  input  1  asynchronous, active-high reset
- readRegister  input  NUM_READ x ADDR_WIDTH  read addresses, sampled at clk edge
- readData  output  NUM_READ x DATA_WIDTH  registered read data
- writeRegister  input  ADDR_WIDTH  write address
- writeData  input  DATA_WIDTH  write data
- regWrite  input  1  write enable
- clearReq  input  1  single-cycle pulse requesting a full clear
- ready  output  1  1 = IDLE; writes accepted and reads return array contents

## Operation
- FSM states:
  - CLEAR: walks clrIdx from 0 to DEPTH-1, writing zero to one entry per cycle. Enters IDLE on the edge that clears DEPTH-1.
  - IDLE: normal operation. clearReq=1 goes to CLEAR with clrIdx=0.
- Reset: state=CLEAR, clrIdx=0, every readData=0, ready=0. Array contents are undefined until the clear completes.
- Reads in IDLE: on each edge, readData[i] <= mem[readRegister[i]].
  - If ZERO_REG=1 and readRegister[i]=0, the port returns 0.
- Bypass: if BYPASS=1, regWrite=1, writeRegister==readRegister[i], and the target is not the zero register, readData[i] <= writeData (write-first).
  - If BYPASS=0, the port returns the old contents (read-first).
- Writes in IDLE: if regWrite=1, mem[writeRegister] <= writeData.
  - A write to register 0 is dropped when ZERO_REG=1.
- Reads in CLEAR: every readData <= 0. Writes are dropped.
- clearReq in CLEAR is ignored; the clear is not restarted.
- clearReq and regWrite in the same IDLE cycle: the clear wins and the write is dropped. Reads in that cycle still complete normally, including bypass.
- Several read ports may use the same address; each port receives identical data.
- Reset asserted mid-clear or mid-operation: immediate return to the reset state. The clear restarts from clrIdx=0.

## Timing
- Read latency: 1 cycle. An address presented before edge N yields data after edge N, stable until edge N+1.
- Write latency: 1 cycle. The write is visible to reads sampled at edge N+1, or at edge N when bypassed.
- Clear duration: exactly DEPTH edges. ready rises after the DEPTH-th edge following reset deassertion or clearReq acceptance (32 edges at the defaults).
- ready is decoded from state, with no extra register stage.
- Async reset is not synchronised internally; deassertion must meet clk recovery/removal.

## Structure
- Package register_file_pkg:
  - state enum rf_state_t {RF_CLEAR, RF_IDLE}
  - default width constants RF_DATA_WIDTH=64, RF_ADDR_WIDTH=5
- Sub-module register_file_read_port: zero-register check, bypass compare/mux, and output register for one port. It is generated NUM_READ times.
- Storage array, write decode, clear counter and FSM stay in the top module.

## Test plan
- Reset then idle for 32 cycles: ready=0 through edge 31, ready=1 after edge 32; all readData=0 throughout.
- After ready: write 0xDEAD_BEEF_0000_0001 to r5. Next cycle read r5 on port 0 and port 1 → both return 0xDEADBEEF00000001 one cycle later.
- Same-cycle write 0x1234 to r7 and read r7:
  - BYPASS=1 → 0x1234
  - BYPASS=0 → previous value 0
- Write 0xFFFF to r0 with ZERO_REG=1, then read r0 → 0. With ZERO_REG=0 → 0xFFFF.
- Fill r1..r3 with 1, 2, 3, then pulse clearReq together with regWrite r4=9:
  - ready=0 for 32 cycles
  - reads during the clear → 0
  - afterwards r1..r4 all read 0
- Assert reset at clear cycle 10, release: ready stays 0 for a full 32 further edges. r20 (written before the clear) reads 0 afterwards.

Source files
------------

// File: rtl/register_file_pkg.sv
// Shared types and default sizing for the multi-port register file.
package register_file_pkg;

    localparam int unsigned RF_DATA_WIDTH = 64;
    localparam int unsigned RF_ADDR_WIDTH = 5;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_IDLE  = 1'b1
    } rf_state_t;

endpackage

// File: rtl/register_file_mp_if.sv
// Decode-side bus of the register file: read addresses/data, one write port, clear request.
interface register_file_mp_if
    import register_file_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int unsigned NUM_READ   = 2
);

    logic [NUM_READ-1:0][ADDR_WIDTH-1:0] readRegister;
    logic [NUM_READ-1:0][DATA_WIDTH-1:0] readData;
    logic [ADDR_WIDTH-1:0]               writeRegister;
    logic [DATA_WIDTH-1:0]               writeData;
    logic                                regWrite;
    logic                                clearReq;
    logic                                ready;

    modport master (
        output readRegister, writeRegister, writeData, regWrite, clearReq,
        input  readData, ready
    );

    modport slave (
        input  readRegister, writeRegister, writeData, regWrite, clearReq,
        output readData, ready
    );

endinterface

// File: rtl/register_file_read_port.sv
// One registered read port: zero-register masking, write-first bypass, output flop.
module register_file_read_port #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned ZERO_REG   = 1,
    parameter int unsigned BYPASS     = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  idle,
    input  logic [ADDR_WIDTH-1:0] raddr,
    input  logic [DATA_WIDTH-1:0] mem_data,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  wen,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic                  zero_hit;
    logic                  byp_hit;
    logic [DATA_WIDTH-1:0] rd_next;

    // Bypass ignores clearReq on purpose: reads in the clear-request cycle still forward.
    always_comb begin
        zero_hit = (ZERO_REG != 0) && (raddr == '0);
        byp_hit  = (BYPASS != 0) && wen && (waddr == raddr);
        rd_next  = mem_data;
        if (!idle || zero_hit) begin
            rd_next = '0;
        end else if (byp_hit) begin
            rd_next = wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else begin
            rdata <= rd_next;
        end
    end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file with a clear engine that zeroes every entry after reset or on request.
module register_file_mp
    import register_file_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int unsigned NUM_READ   = 2,
    parameter int unsigned ZERO_REG   = 1,
    parameter int unsigned BYPASS     = 1
) (
    input  logic               clk,
    input  logic               reset,
    register_file_mp_if.slave  bus
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    rf_state_t             state;
    rf_state_t             state_next;
    logic [ADDR_WIDTH-1:0] clr_idx;
    logic                  clr_last;
    logic                  clr_en;
    logic                  idle;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd [NUM_READ];

    assign clr_last = (clr_idx == ADDR_WIDTH'(DEPTH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RF_CLEAR;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RF_CLEAR: if (clr_last)     state_next = RF_IDLE;
            RF_IDLE:  if (bus.clearReq) state_next = RF_CLEAR;
            default:                    state_next = RF_CLEAR;
        endcase
    end

    always_comb begin
        idle   = 1'b0;
        clr_en = 1'b0;
        case (state)
            RF_CLEAR: clr_en = 1'b1;
            RF_IDLE:  idle   = 1'b1;
            default:  clr_en = 1'b1;
        endcase
    end

    assign bus.ready = idle;

    // Counter wraps to zero on the final clear edge, so a later clearReq starts from entry 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clr_idx <= '0;
        end else if (clr_en) begin
            clr_idx <= clr_idx + ADDR_WIDTH'(1);
        end else if (bus.clearReq) begin
            clr_idx <= '0;
        end
    end

    assign wr_en = idle && bus.regWrite && !bus.clearReq &&
                   !((ZERO_REG != 0) && (bus.writeRegister == '0));

    always_ff @(posedge clk) begin
        if (clr_en) begin
            mem[clr_idx] <= '0;
        end else if (wr_en) begin
            mem[bus.writeRegister] <= bus.writeData;
        end
    end

    for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
        register_file_read_port #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH),
            .ZERO_REG   (ZERO_REG),
            .BYPASS     (BYPASS)
        ) u_read_port (
            .clk      (clk),
            .reset    (reset),
            .idle     (idle),
            .raddr    (bus.readRegister[i]),
            .mem_data (mem[bus.readRegister[i]]),
            .waddr    (bus.writeRegister),
            .wdata    (bus.writeData),
            .wen      (bus.regWrite),
            .rdata    (rd[i])
        );
    end

    always_comb begin
        for (int i = 0; i < NUM_READ; i++) begin
            bus.readData[i] = rd[i];
        end
    end

endmodule

// File: tb/tb_register_file_mp.sv
// Drives two register files (zero-reg+bypass, and neither) from one stimulus against an array model.
module tb_register_file_mp;

    logic            clk = 1'b0;
    logic            reset;
    logic [1:0][4:0] rr;
    logic [4:0]      wa;
    logic [63:0]     wd;
    logic            we;
    logic            cr;

    int total = 0;
    int bad   = 0;

    // Model: per-config array contents and edges left until the clear completes.
    logic [63:0] mdl [2][32];
    int          clr_left;

    always #5 clk = ~clk;

    register_file_mp_if #(.DATA_WIDTH(64), .ADDR_WIDTH(5), .NUM_READ(2)) bus_a ();
    register_file_mp_if #(.DATA_WIDTH(64), .ADDR_WIDTH(5), .NUM_READ(2)) bus_b ();

    assign bus_a.readRegister  = rr;
    assign bus_a.writeRegister = wa;
    assign bus_a.writeData     = wd;
    assign bus_a.regWrite      = we;
    assign bus_a.clearReq      = cr;
    assign bus_b.readRegister  = rr;
    assign bus_b.writeRegister = wa;
    assign bus_b.writeData     = wd;
    assign bus_b.regWrite      = we;
    assign bus_b.clearReq      = cr;

    register_file_mp #(.ZERO_REG(1), .BYPASS(1)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    register_file_mp #(.ZERO_REG(0), .BYPASS(0)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] dut_rd(input int k, input int p);
        return (k == 0) ? bus_a.readData[p] : bus_b.readData[p];
    endfunction

    function automatic logic dut_rdy(input int k);
        return (k == 0) ? bus_a.ready : bus_b.ready;
    endfunction

    task automatic model_zero();
        for (int k = 0; k < 2; k++)
            for (int r = 0; r < 32; r++)
                mdl[k][r] = '0;
    endtask

    // One clock: apply inputs, predict outputs from the model, compare after the edge.
    task automatic step(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] w_a,
                        input logic [63:0] w_d, input logic w_e, input logic c_r);
        logic [63:0] exp_rd [2][2];
        logic [4:0]  addr;
        logic        exp_rdy;
        rr[0] = a0; rr[1] = a1; wa = w_a; wd = w_d; we = w_e; cr = c_r;
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < 2; p++) begin
                addr = (p == 0) ? a0 : a1;
                if (clr_left > 0)                         exp_rd[k][p] = '0;
                else if (k == 0 && addr == 5'd0)          exp_rd[k][p] = '0;
                else if (k == 0 && w_e && w_a == addr)    exp_rd[k][p] = w_d;
                else                                      exp_rd[k][p] = mdl[k][addr];
            end
        end
        if (clr_left > 0) begin
            clr_left--;
        end else if (c_r) begin
            clr_left = 32;
            model_zero();
        end else if (w_e) begin
            for (int k = 0; k < 2; k++)
                if (!(k == 0 && w_a == 5'd0)) mdl[k][w_a] = w_d;
        end
        exp_rdy = (clr_left == 0);
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < 2; p++)
                check($sformatf("rd%0d_p%0d", k, p), dut_rd(k, p), exp_rd[k][p]);
            check($sformatf("ready%0d", k), {63'b0, dut_rdy(k)}, {63'b0, exp_rdy});
        end
    endtask

    task automatic do_reset();
        we = 1'b0; cr = 1'b0;
        reset = 1'b1;
        #2;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst_rd%0d_p0", k), dut_rd(k, 0), 64'd0);
            check($sformatf("rst_rd%0d_p1", k), dut_rd(k, 1), 64'd0);
            check($sformatf("rst_ready%0d", k), {63'b0, dut_rdy(k)}, 64'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        clr_left = 32;
        model_zero();
    endtask

    function automatic logic [4:0] raddr();
        return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
    endfunction

    initial begin
        reset = 1'b0;
        rr = '0; wa = '0; wd = '0; we = 1'b0; cr = 1'b0;
        clr_left = 32;
        model_zero();
        #1;
        do_reset();

        repeat (32) step(raddr(), raddr(), 5'd0, 64'd0, 1'b0, 1'b0);
        check("ready_after_clear", {63'b0, bus_a.ready}, 64'd1);

        step(5'd0, 5'd0, 5'd5, 64'hDEAD_BEEF_0000_0001, 1'b1, 1'b0);
        step(5'd5, 5'd5, 5'd0, 64'd0, 1'b0, 1'b0);
        check("r5_p0", bus_a.readData[0], 64'hDEAD_BEEF_0000_0001);
        check("r5_p1", bus_a.readData[1], 64'hDEAD_BEEF_0000_0001);

        step(5'd7, 5'd7, 5'd7, 64'h1234, 1'b1, 1'b0);
        check("byp_r7", bus_a.readData[0], 64'h1234);
        check("nobyp_r7", bus_b.readData[0], 64'h0);

        step(5'd0, 5'd0, 5'd0, 64'hFFFF, 1'b1, 1'b0);
        step(5'd0, 5'd0, 5'd0, 64'd0, 1'b0, 1'b0);
        check("zr_r0", bus_a.readData[0], 64'h0);
        check("nozr_r0", bus_b.readData[0], 64'hFFFF);

        step(5'd0, 5'd0, 5'd1, 64'd1, 1'b1, 1'b0);
        step(5'd0, 5'd0, 5'd2, 64'd2, 1'b1, 1'b0);
        step(5'd0, 5'd0, 5'd3, 64'd3, 1'b1, 1'b0);
        step(5'd1, 5'd4, 5'd4, 64'd9, 1'b1, 1'b1);
        check("clr_cycle_rd_r1", bus_a.readData[0], 64'd1);
        check("clr_cycle_byp_r4", bus_a.readData[1], 64'd9);
        repeat (32) step(raddr(), raddr(), raddr(), {$urandom, $urandom},
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        step(5'd1, 5'd2, 5'd0, 64'd0, 1'b0, 1'b0);
        step(5'd3, 5'd4, 5'd0, 64'd0, 1'b0, 1'b0);
        check("post_clr_r4", bus_b.readData[1], 64'd0);

        step(5'd0, 5'd0, 5'd20, 64'h55, 1'b1, 1'b0);
        step(5'd0, 5'd0, 5'd0, 64'd0, 1'b0, 1'b1);
        repeat (10) step(raddr(), raddr(), 5'd0, 64'd0, 1'b0, 1'b0);
        do_reset();
        repeat (31) step(raddr(), raddr(), 5'd0, 64'd0, 1'b0, 1'b0);
        check("ready_low_edge31", {63'b0, bus_a.ready}, 64'd0);
        step(5'd0, 5'd0, 5'd0, 64'd0, 1'b0, 1'b0);
        step(5'd20, 5'd20, 5'd0, 64'd0, 1'b0, 1'b0);
        check("r20_after_reset", bus_b.readData[0], 64'd0);

        repeat (800) step(raddr(), raddr(), raddr(), {$urandom, $urandom},
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 79) == 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
